bit_collector: RTL
==================

# bit_collector

Serial-to-parallel sink for the core array's output stream. Each cycle with `valid_bit` high carries one `output_bit`; the block packs these bits into `WORD_WIDTH`-bit words and buffers them in a small FIFO. A downstream consumer, such as the VGA pixel path, drains the FIFO through a ready/valid handshake. It connects directly to the core array's `valid_bit`/`output_bit` pair.

## Interface
Parameters:
- `WORD_WIDTH`, 8 — bits per assembled word; must be ≥ 2.
- `FIFO_DEPTH`, 4 — word buffer entries; must be a power of two, ≥ 2.

Ports:
- `clk` — input, 1 — the single clock; all logic is on its rising edge.
- `reset` — input, 1 — reset is synchronous and active-high.
- `valid_bit` — input, 1 — `output_bit` is valid this cycle.
- `output_bit` — input, 1 — serial data bit; words are sent LSB first.
- `flush` — input, 1 — discard the partially assembled word.
- `word_data` — output, `WORD_WIDTH` — FIFO head word; forced to 0 while `word_valid` is low.
- `word_valid` — output, 1 — FIFO is non-empty.
- `word_ready` — input, 1 — consumer accepts `word_data` this cycle.
- `overflow` — output, 1 — sticky flag: a completed word was dropped.
- `clear_overflow` — input, 1 — clears `overflow`.
- `level` — output, `$clog2(FIFO_DEPTH+1)` — number of words in the FIFO.
- `drop_count` — output, 8 — dropped-word counter; present only with `BIT_COLLECTOR_DROP_CNT_EN`.

## Operation
- **Shift register `sr`:** on each cycle with `valid_bit` high, `sr <= {output_bit, sr[WORD_WIDTH-1:1]}`. The first bit received ends up in bit 0.
- **Bit counter `bcnt`:** counts 0..`WORD_WIDTH-1`.
  - A bit accepted while `bcnt == WORD_WIDTH-1` completes a word. The completed word is `{output_bit, sr[WORD_WIDTH-1:1]}`, and `bcnt` wraps to 0.
  - Otherwise `bcnt` increments.
- **Push:** a completed word is pushed if the FIFO is not full, or if it is full but a pop occurs in the same cycle (simultaneous push and pop on a full FIFO is legal).
- **Drop:** otherwise the completed word is discarded and `overflow` is set. With the macro, `drop_count` also increments.
- **Pop:** a pop occurs when `word_valid && word_ready`. `word_ready` while empty has no effect.
- **`flush`:** clears `sr` and `bcnt` and has priority over `valid_bit` in the same cycle; that bit is discarded. Buffered FIFO words are untouched.
- **`overflow` / `clear_overflow`:** if `clear_overflow` and a new drop coincide, `overflow` stays 1.
- **`level`:** increments on push only, decrements on pop only, unchanged when both or neither occur.

## Timing
- **Reset values:** `word_valid`=0, `word_data`=0, `overflow`=0, `level`=0, `drop_count`=0, `sr`=0, `bcnt`=0, FIFO pointers 0.
- **Latency:** the completing bit is sampled at edge N. `word_valid`, `word_data` and `level` reflect the new word after edge N, i.e. visible in cycle N+1. The FIFO is first-word-fall-through, so `word_data` is combinational from the head entry.
- **Throughput:** one bit per cycle sustained. After a pop at edge M, the next head is visible after edge M.
- **Pointer wrap:** read and write pointers wrap modulo `FIFO_DEPTH`. Full/empty are distinguished by `level`, not by pointer equality alone.
- **Reset mid-word:** the partial word is lost, all buffered words are lost, and no drop is counted.

## Configuration
- **`BIT_COLLECTOR_DROP_CNT_EN` defined:**
  - `drop_count` port exists.
  - Counts dropped words and saturates at 255; it does not wrap.
  - Cleared by `reset` or `clear_overflow`. A drop in the same cycle as `clear_overflow` leaves the count at 1.
- **Not defined:** port and counter are absent; `overflow` behaviour is unchanged.

## Structure
- Shared constants header/package `bit_collector_pkg`: default `WORD_WIDTH`, default `FIFO_DEPTH`, `DROP_CNT_WIDTH` = 8.
- Sub-module `sync_fifo`: parameterised by width and depth, with push, pop, full, empty, level and a fall-through head.
- `bit_collector` itself holds `sr`, `bcnt`, the push/drop decision, the overflow flag and the counter.

## Test plan
All scenarios use `WORD_WIDTH`=8, `FIFO_DEPTH`=4.
1. Reset, then bits 1,0,1,1,0,0,0,0 on consecutive cycles with `word_ready`=0 → after the 8th edge: `word_valid`=1, `word_data`=0x0D, `level`=1.
2. Five full words 0x01..0x05 with `word_ready`=0 → `level`=4, `overflow`=1, `drop_count`=1 with macro; pops then return 0x01..0x04 in order.
3. FIFO full; the 8th bit of word 0x55 arrives in the same cycle as `word_ready`=1 → 0x55 is pushed, `level` stays 4, `overflow` stays 0.
4. Bits 1,1,1 then `flush` together with `valid_bit`=1, then 8 bits forming 0xA5 → the FIFO holds only 0xA5.
5. Bits sent with gaps (`valid_bit` low on alternate cycles) forming 0x3C → single word 0x3C; `level` unchanged on idle cycles.
6. 300 drops, then `clear_overflow` → `drop_count` reads 255 before the clear, then 0 with `overflow`=0.

Source files
------------

// File: rtl/bit_collector_pkg.sv
// Shared constants for the bit collector: default geometry and drop counter width.
package bit_collector_pkg;

    localparam int unsigned DEF_WORD_WIDTH = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DROP_CNT_WIDTH = 8;
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty come from the occupancy count,
// so pointers may wrap freely. DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LW = $clog2(DEPTH + 1),
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [LW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when a read frees the head in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];
    assign level   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bit_collector.sv
// Packs an LSB-first serial bit stream into words and buffers them for a ready/valid consumer.
// Define BIT_COLLECTOR_DROP_CNT_EN to add the saturating drop_count output.
module bit_collector
    import bit_collector_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1),
    localparam int unsigned BW = $clog2(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_bit,
    input  logic                  output_bit,
    input  logic                  flush,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  overflow,
    input  logic                  clear_overflow,
    output logic [LW-1:0]         level
`ifdef BIT_COLLECTOR_DROP_CNT_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
`endif
);

    logic [WORD_WIDTH-1:0] sr;
    logic [WORD_WIDTH-1:0] word_next;
    logic [WORD_WIDTH-1:0] head;
    logic [BW-1:0]         bcnt;
    logic                  word_done;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign word_next  = {output_bit, sr[WORD_WIDTH-1:1]};
    assign word_done  = valid_bit && !flush && (bcnt == BW'(WORD_WIDTH - 1));
    assign word_valid = !fifo_empty;
    assign word_data  = word_valid ? head : '0;
    assign pop        = word_valid && word_ready;
    assign push       = word_done && (!fifo_full || pop);
    assign drop       = word_done && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            sr   <= '0;
            bcnt <= '0;
        end else if (valid_bit) begin
            sr   <= word_next;
            bcnt <= word_done ? '0 : bcnt + 1'b1;
        end
    end

    // A drop wins over a coincident clear so no loss goes unreported.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef BIT_COLLECTOR_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (clear_overflow) begin
            drop_count <= drop ? DROP_CNT_WIDTH'(1) : '0;
        end else if (drop && (drop_count != DROP_CNT_MAX)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

    sync_fifo #(
        .WIDTH(WORD_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata(word_next),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty),
        .level(level)
    );

endmodule
